coherence_bus_arbiter: RTL and testbench

//  Round-robin arbiter and broadcaster for the shared coherence request bus.

---
 rtl/cache_types_pkg.sv | 33 +++
 rtl/rr_priority_picker.sv | 30 +++
 rtl/coherence_bus_arbiter.sv | 90 +++++++++
 tb/tb_coherence_bus_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared coherence types: request/response bus messages and arbiter FSM states.
package cache_types;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    CMD_RD   = 2'd0,
    CMD_RDX  = 2'd1,
    CMD_UPG  = 2'd2,
    CMD_WB   = 2'd3
  } coh_cmd_t;

  typedef struct packed {
    logic            valid;
    coh_cmd_t        cmd;
    logic [XLEN-1:0] addr;
    logic [1:0]      src;
  } req_msg_t;

  typedef struct packed {
    logic            valid;
    logic            shared;
    logic [XLEN-1:0] data;
    logic [1:0]      dst;
  } resp_msg_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_HOLD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_priority_picker #(
  parameter int NUM_PORTS = 4,
  parameter int ID_BITS   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_BITS-1:0]   rr_ptr,
  output logic [NUM_PORTS-1:0] pick,
  output logic [ID_BITS-1:0]   pick_idx,
  output logic                 found
);

  logic [ID_BITS-1:0] j;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    j        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = ID_BITS'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!found && req[j]) begin
        found    = 1'b1;
        pick_idx = j;
        pick[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Round-robin owner arbitration for a shared coherence bus: one broadcast per
// grant, ownership held while the owner requests or any snooper is busy.
module coherence_bus_arbiter
  import cache_types::*;
#(
  parameter int  NUM_PORTS = 4,
  parameter int  ID_BITS   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int  MAX_HOLD  = 64,
  parameter type MSG_T     = req_msg_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PORTS-1:0]  bus_req,
  input  MSG_T [NUM_PORTS-1:0]  bus_tx,
  input  logic [NUM_PORTS-1:0]  bus_busy,
  output logic [NUM_PORTS-1:0]  bus_gnt,
  output MSG_T                  bus_msg,
  output logic [ID_BITS-1:0]    bus_owner,
  output logic                  hold_err
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_t             state, state_d;
  logic [ID_BITS-1:0]     rr_ptr;
  logic [CNT_W-1:0]       hold_cnt;
  logic [NUM_PORTS-1:0]   pick;
  logic [ID_BITS-1:0]     pick_idx;
  logic                   found;
  logic                   rel;

  rr_priority_picker #(.NUM_PORTS(NUM_PORTS), .ID_BITS(ID_BITS)) u_pick (
    .req      (bus_req),
    .rr_ptr   (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .found    (found)
  );

  always_comb begin
    state_d = state;
    rel     = 1'b0;
    case (state)
      ARB_IDLE:  if (found) state_d = ARB_GRANT;
      ARB_GRANT: state_d = ARB_HOLD;
      ARB_HOLD: begin
        rel = !(bus_req[bus_owner] || (|bus_busy));
        if (rel) state_d = ARB_IDLE;
      end
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Fields stay driven during HOLD so slow snoopers can keep reading them.
  always_comb begin
    bus_msg = '0;
    if (state != ARB_IDLE) begin
      bus_msg       = bus_tx[bus_owner];
      bus_msg.valid = (state == ARB_GRANT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      bus_gnt   <= '0;
      bus_owner <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      hold_err  <= 1'b0;
    end else begin
      state <= state_d;
      if (state == ARB_IDLE && found) begin
        bus_gnt   <= pick;
        bus_owner <= pick_idx;
        hold_cnt  <= '0;
      end
      if (rel) begin
        bus_gnt <= '0;
        rr_ptr  <= (bus_owner == ID_BITS'(NUM_PORTS - 1)) ? '0 : bus_owner + 1'b1;
      end
      // Watchdog only flags; arbitration is never forced.
      if (state == ARB_HOLD && hold_cnt != CNT_W'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == CNT_W'(MAX_HOLD - 1)) hold_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: vector table plus hand sequences.
module tb_coherence_bus_arbiter;
  import cache_types::*;

  logic           clk;
  logic           rst;
  logic [3:0]     bus_req;
  req_msg_t [3:0] bus_tx;
  logic [3:0]     bus_busy;
  logic [3:0]     bus_gnt;
  req_msg_t       bus_msg;
  logic [1:0]     bus_owner;
  logic           hold_err;

  int checks = 0;
  int errors = 0;

  coherence_bus_arbiter #(.NUM_PORTS(4), .MAX_HOLD(8), .MSG_T(req_msg_t)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_tx    (bus_tx),
    .bus_busy  (bus_busy),
    .bus_gnt   (bus_gnt),
    .bus_msg   (bus_msg),
    .bus_owner (bus_owner),
    .hold_err  (hold_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] owner;
    logic       err;
  } vec_t;

  localparam int NV = 22;
  vec_t vt[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic req_msg_t exp_msg(input logic [3:0] g, input logic v, input logic [1:0] o);
    req_msg_t m;
    m = '0;
    if (g != 4'b0000) begin
      m       = bus_tx[o];
      m.valid = v;
    end
    return m;
  endfunction

  task automatic chk_state(input string nm, input logic [3:0] g, input logic v,
                           input logic [1:0] o, input logic e);
    chk({nm, "_gnt"}, 64'(bus_gnt), 64'(g));
    chk({nm, "_msg"}, 64'(bus_msg), 64'(exp_msg(g, v, o)));
    if (g != 4'b0000) chk({nm, "_owner"}, 64'(bus_owner), 64'(o));
    chk({nm, "_err"}, 64'(hold_err), 64'(e));
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      bus_tx[p].valid = 1'b0;
      bus_tx[p].cmd   = coh_cmd_t'(p);
      bus_tx[p].addr  = 32'hA000_0000 + 32'(p);
      bus_tx[p].src   = 2'(p);
    end

    //          req      busy     gnt      vld   own   err
    // single request to port 2, release leaves rr_ptr at 3
    vt[0]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
    vt[1]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b0};
    vt[2]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0};
    // wrap: rr_ptr=3, ports 3 and 0 request
    vt[3]  = '{4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
    vt[4]  = '{4'b1001, 4'b0000, 4'b1000, 1'b0, 2'd3, 1'b0};
    vt[5]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};
    vt[6]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    vt[7]  = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0};
    vt[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    // owner drops req, snooper 1 busy for 5 cycles keeps the grant
    vt[9]  = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
    vt[10] = '{4'b0000, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0};
    vt[11] = '{4'b0000, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0};
    vt[12] = '{4'b0000, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0};
    vt[13] = '{4'b0000, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0};
    vt[14] = '{4'b0000, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0};
    vt[15] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0};
    // previous owner 1 re-requests alongside port 0: port 0 wins
    vt[16] = '{4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    vt[17] = '{4'b0010, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0};
    vt[18] = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[19] = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
    vt[20] = '{4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd1, 1'b0};
    vt[21] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0};

    rst      = 1'b1;
    bus_req  = '0;
    bus_busy = '0;
    step();
    step();
    chk("rst_gnt", 64'(bus_gnt), 64'(0));
    chk("rst_msg", 64'(bus_msg), 64'(0));
    chk("rst_owner", 64'(bus_owner), 64'(0));
    chk("rst_err", 64'(hold_err), 64'(0));
    rst = 1'b0;
    step();
    chk("idle_gnt", 64'(bus_gnt), 64'(0));

    for (int i = 0; i < NV; i++) begin
      bus_req  = vt[i].req;
      bus_busy = vt[i].busy;
      step();
      chk_state($sformatf("vec%0d", i), vt[i].gnt, vt[i].valid, vt[i].owner, vt[i].err);
    end

    // watchdog: rr_ptr=2, port 3 granted, all snoopers busy 10 cycles
    bus_req = 4'b1000;
    step();
    chk_state("wd_grant", 4'b1000, 1'b1, 2'd3, 1'b0);
    bus_req  = 4'b0000;
    bus_busy = 4'b1111;
    for (int s = 1; s <= 10; s++) begin
      step();
      chk($sformatf("wd_hold%0d_gnt", s), 64'(bus_gnt), 64'(4'b1000));
      chk($sformatf("wd_hold%0d_msg", s), 64'(bus_msg), 64'(exp_msg(4'b1000, 1'b0, 2'd3)));
      if (s == 8) chk("wd_err_before", 64'(hold_err), 64'(0));
      if (s == 9) chk("wd_err_set", 64'(hold_err), 64'(1));
    end
    bus_busy = 4'b0000;
    step();
    chk_state("wd_release", 4'b0000, 1'b0, 2'd3, 1'b1);
    bus_req = 4'b0001;
    step();
    chk_state("wd_next", 4'b0001, 1'b1, 2'd0, 1'b1);
    bus_req = 4'b0000;
    step();
    step();
    chk_state("wd_next_rel", 4'b0000, 1'b0, 2'd0, 1'b1);

    // async reset mid-cycle while holding
    bus_req = 4'b0100;
    step();
    chk_state("rs_grant", 4'b0100, 1'b1, 2'd2, 1'b1);
    bus_req  = 4'b0000;
    bus_busy = 4'b1111;
    step();
    step();
    chk_state("rs_hold", 4'b0100, 1'b0, 2'd2, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("rs_gnt", 64'(bus_gnt), 64'(0));
    chk("rs_msg", 64'(bus_msg), 64'(0));
    chk("rs_err", 64'(hold_err), 64'(0));
    chk("rs_owner", 64'(bus_owner), 64'(0));
    #1 rst = 1'b0;
    bus_busy = 4'b0000;

    // all four request continuously; each releases after one HOLD cycle
    for (int k = 0; k < 5; k++) begin
      logic [1:0] o;
      logic [3:0] g;
      o = 2'(k % 4);
      g = 4'b0001 << o;
      bus_req = 4'b1111;
      step();
      chk_state($sformatf("rot%0d_grant", k), g, 1'b1, o, 1'b0);
      step();
      chk_state($sformatf("rot%0d_hold", k), g, 1'b0, o, 1'b0);
      bus_req = 4'b1111 & ~g;
      step();
      chk_state($sformatf("rot%0d_rel", k), 4'b0000, 1'b0, o, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
